// File: rtl/ddr_a2m_burst_agen_pkg.sv
// ddr_a2m_burst_agen_pkg: shared AXI burst/size encodings, legal wrap lengths and agen FSM states
package ddr_a2m_burst_agen_pkg;
  localparam logic [1:0] P_BURST_FIXED = 2'd0;
  localparam logic [1:0] P_BURST_INCR  = 2'd1;
  localparam logic [1:0] P_BURST_WRAP  = 2'd2;
  localparam logic [1:0] P_BURST_RSVD  = 2'd3;
  localparam logic [2:0] P_ASIZE_1   = 3'd0;
  localparam logic [2:0] P_ASIZE_2   = 3'd1;
  localparam logic [2:0] P_ASIZE_4   = 3'd2;
  localparam logic [2:0] P_ASIZE_8   = 3'd3;
  localparam logic [2:0] P_ASIZE_16  = 3'd4;
  localparam logic [2:0] P_ASIZE_32  = 3'd5;
  localparam logic [2:0] P_ASIZE_64  = 3'd6;
  localparam logic [2:0] P_ASIZE_128 = 3'd7;
  localparam logic [7:0] P_WRAP_LEN2  = 8'd1;
  localparam logic [7:0] P_WRAP_LEN4  = 8'd3;
  localparam logic [7:0] P_WRAP_LEN8  = 8'd7;
  localparam logic [7:0] P_WRAP_LEN16 = 8'd15;
  localparam logic [7:0] P_FIXED_MAX_LEN = 8'd15;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
endpackage

// File: rtl/ddr_a2m_agen_wmask.sv
// ddr_a2m_agen_wmask: burst byte-span mask ((LEN+1)<<SIZE)-1 and wrap-length legality
module ddr_a2m_agen_wmask
  import ddr_a2m_burst_agen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  output logic [ADDR_W-1:0] mask_o,
  output logic              legal_o
);
  assign mask_o  = (ADDR_W'({1'b0, len_i} + 9'd1) << size_i) - ADDR_W'(1);
  assign legal_o = (len_i == P_WRAP_LEN2) | (len_i == P_WRAP_LEN4) |
                   (len_i == P_WRAP_LEN8) | (len_i == P_WRAP_LEN16);
endmodule

// File: rtl/ddr_a2m_burst_agen.sv
// ddr_a2m_burst_agen: per-beat AXI address generator (FIXED/INCR/WRAP) with valid/ready beats.
// Optional DDR_A2M_AGEN_4K_CHK_EN flags INCR bursts crossing a 4 KB page as erroneous.
module ddr_a2m_burst_agen
  import ddr_a2m_burst_agen_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int ID_W          = 4,
  parameter int MAX_SIZE_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]        cmd_len_i,
  input  logic [2:0]        cmd_size_i,
  input  logic [1:0]        cmd_burst_i,
  input  logic [ID_W-1:0]   cmd_id_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic [7:0]        beat_num_o,
  output logic              beat_last_o,
  output logic [ID_W-1:0]   beat_id_o,
  output logic              beat_err_o
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mask_q, mask_d;
  logic [7:0]        num_q, num_d, len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] cmd_mask, cmd_s, step_s, nxt_addr;
  logic              wrap_legal, err_c, page_err, accept, beat_hs;
  ddr_a2m_agen_wmask #(.ADDR_W(ADDR_W)) u_wmask (
    .len_i   (cmd_len_i),
    .size_i  (cmd_size_i),
    .mask_o  (cmd_mask),
    .legal_o (wrap_legal)
  );
  assign beat_valid_o = (state_q == ST_BUSY);
  assign beat_last_o  = beat_valid_o & (num_q == len_q);
  assign cmd_ready_o  = ~beat_valid_o | (beat_ready_i & beat_last_o);
  assign accept       = cmd_valid_i & cmd_ready_o;
  assign beat_hs      = beat_valid_o & beat_ready_i;
  assign beat_addr_o  = addr_q;
  assign beat_num_o   = num_q;
  assign beat_id_o    = id_q;
  assign beat_err_o   = err_q;
  assign cmd_s        = ADDR_W'(1) << cmd_size_i;
  assign step_s       = ADDR_W'(1) << size_q;
`ifdef DDR_A2M_AGEN_4K_CHK_EN
  logic [ADDR_W-1:0] end_addr;
  // cmd_mask is the burst span minus one, so this is the last byte of the burst
  assign end_addr = (cmd_addr_i & ~(cmd_s - ADDR_W'(1))) + cmd_mask;
  assign page_err = (cmd_burst_i == P_BURST_INCR) & (end_addr[ADDR_W-1:12] != cmd_addr_i[ADDR_W-1:12]);
`else
  assign page_err = 1'b0;
`endif
  assign err_c = (cmd_size_i > 3'(MAX_SIZE_LOG2)) | (cmd_burst_i == P_BURST_RSVD) |
                 ((cmd_burst_i == P_BURST_WRAP) & (~wrap_legal | (|(cmd_addr_i & (cmd_s - ADDR_W'(1)))))) |
                 ((cmd_burst_i == P_BURST_FIXED) & (cmd_len_i > P_FIXED_MAX_LEN)) | page_err;
  assign nxt_addr = (mode_q == P_BURST_FIXED) ? addr_q :
                    (mode_q == P_BURST_WRAP)  ? (addr_q & ~mask_q) | ((addr_q + step_s) & mask_q) :
                                                (addr_q & ~(step_s - ADDR_W'(1))) + step_s;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    num_d   = num_q;
    len_d   = len_q;
    id_d    = id_q;
    err_d   = err_q;
    mode_d  = mode_q;
    size_d  = size_q;
    if (accept) begin
      state_d = ST_BUSY;
      addr_d  = cmd_addr_i;
      mask_d  = cmd_mask;
      num_d   = 8'd0;
      len_d   = cmd_len_i;
      id_d    = cmd_id_i;
      err_d   = err_c;
      size_d  = cmd_size_i;
      // erroneous WRAP and reserved bursts step as INCR
      mode_d  = (cmd_burst_i == P_BURST_FIXED) ? P_BURST_FIXED :
                (cmd_burst_i == P_BURST_WRAP && !err_c) ? P_BURST_WRAP : P_BURST_INCR;
    end else if (beat_hs) begin
      state_d = beat_last_o ? ST_IDLE : ST_BUSY;
      num_d   = beat_last_o ? num_q : num_q + 8'd1;
      addr_d  = beat_last_o ? addr_q : nxt_addr;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      num_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      mode_q  <= P_BURST_FIXED;
      size_q  <= P_ASIZE_1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      len_q   <= len_d;
      id_q    <= id_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      size_q  <= size_d;
    end
  end
endmodule

// File: tb/tb_ddr_a2m_burst_agen.sv
// tb_ddr_a2m_burst_agen: directed and random bursts checked against a closed-form beat model
module tb_ddr_a2m_burst_agen;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } cmd_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  num;
    logic        last;
    logic [3:0]  id;
    logic        err;
  } beat_t;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic [2:0]  cmd_size_i = '0;
  logic [1:0]  cmd_burst_i = '0;
  logic [3:0]  cmd_id_i = '0;
  logic        beat_valid_o;
  logic        beat_ready_i = 1'b0;
  logic [31:0] beat_addr_o;
  logic [7:0]  beat_num_o;
  logic        beat_last_o;
  logic [3:0]  beat_id_o;
  logic        beat_err_o;
  int checks = 0;
  int passed = 0;
  int fails = 0;
  beat_t exp_q[$];
  cmd_t  cq[$];
  always #5 clk_i = ~clk_i;
  ddr_a2m_burst_agen dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_size_i   (cmd_size_i),
    .cmd_burst_i  (cmd_burst_i),
    .cmd_id_i     (cmd_id_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_addr_o  (beat_addr_o),
    .beat_num_o   (beat_num_o),
    .beat_last_o  (beat_last_o),
    .beat_id_o    (beat_id_o),
    .beat_err_o   (beat_err_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic cmd_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] i);
    cmd_t c;
    c.addr = a; c.len = l; c.size = s; c.burst = b; c.id = i;
    return c;
  endfunction
  function automatic bit model_err(input cmd_t c);
    logic [31:0] s, first, lastb;
    bit e;
    s = 32'd1 << c.size;
    e = (c.size > 3'd4) || (c.burst == 2'd3) ||
        (c.burst == 2'd2 && !(c.len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
        (c.burst == 2'd2 && (c.addr % s) != 0) ||
        (c.burst == 2'd0 && c.len > 8'd15);
    first = c.addr - (c.addr % s);
    lastb = first + (32'(c.len) + 32'd1) * s - 32'd1;
`ifdef DDR_A2M_AGEN_4K_CHK_EN
    if (c.burst == 2'd1 && lastb[31:12] != first[31:12]) e = 1'b1;
`endif
    return e;
  endfunction
  function automatic void push_beats(input cmd_t c);
    logic [31:0] s, total, base;
    beat_t b;
    bit e;
    e = model_err(c);
    s = 32'd1 << c.size;
    total = (32'(c.len) + 32'd1) * s;
    for (int i = 0; i <= int'(c.len); i++) begin
      if (c.burst == 2'd0) b.addr = c.addr;
      else if (c.burst == 2'd2 && !e) begin
        base = c.addr - (c.addr % total);
        b.addr = base + ((c.addr + 32'(i) * s) % total);
      end else b.addr = (i == 0) ? c.addr : (c.addr - (c.addr % s)) + 32'(i) * s;
      b.num = 8'(i);
      b.last = (i == int'(c.len));
      b.id = c.id;
      b.err = e;
      exp_q.push_back(b);
    end
  endfunction
  // Drives every command in cq as early as the DUT accepts it; inputs change on the falling edge.
  task automatic run(input bit stall, input int rst_num);
    int ci = 0;
    int budget = 0;
    bit exp_rdy;
    while ((ci < cq.size() || exp_q.size() > 0) && budget < 5000) begin
      beat_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      cmd_valid_i = (ci < cq.size());
      if (ci < cq.size()) begin
        cmd_addr_i = cq[ci].addr; cmd_len_i = cq[ci].len; cmd_size_i = cq[ci].size;
        cmd_burst_i = cq[ci].burst; cmd_id_i = cq[ci].id;
      end
      #1;
      chk("beat_valid", beat_valid_o, exp_q.size() != 0);
      if (exp_q.size() > 0) begin
        chk("beat_addr", beat_addr_o, exp_q[0].addr);
        chk("beat_num", beat_num_o, exp_q[0].num);
        chk("beat_last", beat_last_o, exp_q[0].last);
        chk("beat_id", beat_id_o, exp_q[0].id);
        chk("beat_err", beat_err_o, exp_q[0].err);
      end
      exp_rdy = (exp_q.size() == 0) || (beat_ready_i && exp_q[0].last);
      chk("cmd_ready", cmd_ready_o, exp_rdy);
      if (rst_num >= 0 && exp_q.size() > 0 && int'(exp_q[0].num) == rst_num) begin
        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rst_beat_valid", beat_valid_o, 1'b0);
        chk("rst_cmd_ready", cmd_ready_o, 1'b1);
        chk("rst_beat_addr", beat_addr_o, 32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        cq.delete();
        @(negedge clk_i);
        #1;
        chk("post_rst_valid", beat_valid_o, 1'b0);
        return;
      end
      @(posedge clk_i);
      if (exp_q.size() > 0 && beat_ready_i) void'(exp_q.pop_front());
      if (cmd_valid_i && exp_rdy) begin
        push_beats(cq[ci]);
        ci++;
      end
      @(negedge clk_i);
      budget++;
    end
    chk("drain_beats", 32'(exp_q.size()), 0);
    chk("drain_cmds", 32'(cq.size() - ci), 0);
    cmd_valid_i = 1'b0;
    beat_ready_i = 1'b0;
    cq.delete();
  endtask
  initial begin
    cmd_t c;
    logic [7:0] lens [5];
    lens[0] = 8'd0; lens[1] = 8'd1; lens[2] = 8'd3; lens[3] = 8'd7; lens[4] = 8'd15;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid", beat_valid_o, 1'b0);
    chk("rst_addr", beat_addr_o, 32'd0);
    chk("rst_num", beat_num_o, 8'd0);
    chk("rst_last", beat_last_o, 1'b0);
    chk("rst_id", beat_id_o, 4'd0);
    chk("rst_err", beat_err_o, 1'b0);
    chk("rst_ready", cmd_ready_o, 1'b1);
    rst_i = 1'b0;
    @(negedge clk_i);
    cq.push_back(mk(32'h1003, 8'd3, 3'd2, 2'd1, 4'd1));
    cq.push_back(mk(32'h0038, 8'd3, 3'd3, 2'd2, 4'd2));
    cq.push_back(mk(32'h0040, 8'd2, 3'd0, 2'd2, 4'd3));
    cq.push_back(mk(32'h0200, 8'd7, 3'd2, 2'd0, 4'd4));
    run(1'b0, -1);
    cq.push_back(mk(32'h0034, 8'd3, 3'd3, 2'd2, 4'd5));
    cq.push_back(mk(32'h0100, 8'd1, 3'd5, 2'd1, 4'd6));
    cq.push_back(mk(32'h0104, 8'd2, 3'd1, 2'd3, 4'd7));
    cq.push_back(mk(32'h0300, 8'd16, 3'd0, 2'd0, 4'd8));
    cq.push_back(mk(32'h0555, 8'd0, 3'd2, 2'd1, 4'd9));
    cq.push_back(mk(32'h01F0, 8'd15, 3'd4, 2'd2, 4'd10));
    cq.push_back(mk(32'hFFFF_FFF8, 8'd3, 3'd2, 2'd1, 4'd11));
    cq.push_back(mk(32'h0FF0, 8'd3, 3'd3, 2'd1, 4'd12));
    run(1'b0, -1);
    for (int n = 0; n < 40; n++) begin
      c.burst = 2'($urandom_range(0, 3));
      c.size = 3'($urandom_range(0, 5));
      c.len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : lens[$urandom_range(0, 4)];
      c.addr = $urandom;
      if ($urandom_range(0, 1) == 1) c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
      c.id = 4'($urandom);
      cq.push_back(c);
    end
    run(1'b1, -1);
    cq.push_back(mk(32'h0200, 8'd7, 3'd2, 2'd0, 4'd13));
    run(1'b0, 3);
    cq.push_back(mk(32'h2000, 8'd2, 3'd2, 2'd1, 4'd14));
    run(1'b1, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
